button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front end that produces the single-cycle `button` strobes consumed by the game state machine and the other game control logic.
- Per button: synchronises the raw pad input, debounces it, and emits exactly one clean pulse per physical press.
- Also provides a debounced level per button and an OR'd `any_pulse` for the start/pause/restart input.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 250000, cycles the synchronised input must stay stable before a press or release is accepted; must be >= 1.
- REPEAT_DELAY, 5000000, cycles held before the first auto-repeat pulse (BTN_REPEAT_EN only).
- REPEAT_PERIOD, 2500000, cycles between later auto-repeat pulses (BTN_REPEAT_EN only).
- REPEAT_MASK, 5'b11110, per-channel auto-repeat enable; bit 0 (start/pause) never repeats by default.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, asynchronous, active-low
- btn_raw  input  NUM_BTN  raw active-high pad inputs, asynchronous to clk
- btn_pulse  output  NUM_BTN  one-cycle strobe per accepted press (and repeat)
- btn_level  output  NUM_BTN  debounced pressed level
- any_pulse  output  1  OR of btn_pulse, registered in the same cycle as btn_pulse

Behaviour:
- Reset (nrst low, async):
  - synchroniser flops = 0, channel FSMs = IDLE, counters = 0.
  - btn_pulse = 0, btn_level = 0, any_pulse = 0.
- Synchroniser: 2 flops per channel; the FSM samples the second flop (sync).
- Channel FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: sync=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: sync=0 -> IDLE, cnt=0 (bounce rejected, no pulse). sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, pulse<=1. Otherwise cnt++.
  - HELD: sync=0 -> RELEASE_WAIT, cnt=0. Otherwise stay.
  - RELEASE_WAIT: sync=1 -> HELD, cnt=0, no new pulse. sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0. Otherwise cnt++.
- All outputs are registered. btn_pulse is high for exactly one cycle per accepted press. Releases never pulse.
- Latency: btn_raw rises and stays high, first sampled at edge 0. FSM enters PRESS_WAIT at edge 2. btn_pulse and btn_level rise at edge DEBOUNCE_CYCLES+2. btn_pulse falls one edge later.
- Channels are fully independent. Simultaneous presses give simultaneous pulse bits; any_pulse is a single one-cycle high.
- Counter width: $clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, plus 1. Counters never wrap because they are cleared on every state change.
- Reset mid-operation returns everything to the reset values immediately. A button held through reset release is treated as a new press and pulses after the normal latency.

Optional Feature:
- Macro BTN_REPEAT_EN.
- Defined: for channels with REPEAT_MASK bit set, in HELD a repeat counter runs from entry.
  - At REPEAT_DELAY cycles: one extra pulse.
  - Then one pulse every REPEAT_PERIOD cycles while still HELD.
  - Entering RELEASE_WAIT clears the repeat counter. Returning to HELD from RELEASE_WAIT restarts the delay.
- Undefined: no repeat counters are built; REPEAT_* parameters are ignored; one pulse per press only.

Decomposition:
- Shared package (with the game state/mode enums): BTN_STATE enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} and default timing constants.
- Sub-module btn_debounce_ch (synchroniser + FSM + counters, one channel), generated NUM_BTN times. The top ORs the pulses into any_pulse.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_BTN=5):
- Clean press: btn_raw[0] 0->1 before edge 0, held 20 cycles -> btn_pulse[0] and any_pulse high only after edge 6; btn_level[0] high from edge 6.
- Bounce: btn_raw[1] high 2 cycles, low 1, high 2, low -> no pulse, btn_level[1] stays 0.
- Release glitch: btn_raw[2] held, pulse seen, then one 2-cycle low dropout -> no second pulse, btn_level[2] stays 1; full release -> btn_level[2] low after 4+2 edges, no pulse.
- Simultaneous: btn_raw=5'b00101 in the same cycle -> btn_pulse=5'b00101 for one cycle, any_pulse one cycle.
- Reset mid-count: nrst low 1 cycle during PRESS_WAIT -> outputs 0 at once; raw still high after release -> pulse 6 edges after nrst deasserts.
- BTN_REPEAT_EN: btn_raw[3] held 30 cycles -> pulses at edges 6, 16, 19, 22, 25, 28; btn_raw[0] held the same -> single pulse.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared game-control types: button channel FSM states, game state/mode enums
// and default button timing constants.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  typedef enum logic [1:0] {
    GAME_ATTRACT = 2'd0,
    GAME_PLAY    = 2'd1,
    GAME_PAUSE   = 2'd2,
    GAME_OVER    = 2'd3
  } game_state_e;

  typedef enum logic [0:0] {
    MODE_SINGLE = 1'b0,
    MODE_VERSUS = 1'b1
  } game_mode_e;

  localparam int DEF_NUM_BTN         = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 5000000;
  localparam int DEF_REPEAT_PERIOD   = 2500000;
  localparam logic [4:0] DEF_REPEAT_MASK = 5'b11110;

  // Counters are cleared on every state change, so one spare bit above the
  // largest terminal count is enough to guarantee they never wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM and optional
// auto-repeat counter (BTN_REPEAT_EN). Outputs are registered.
module btn_debounce_ch
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef BTN_REPEAT_EN
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0,
`endif
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw,
  output logic pulse,
  output logic pulse_nxt,
  output logic level
);

  logic [1:0]       sync_r;
  logic             sync_s;
  btn_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             level_r, level_s;
  logic             pulse_r;
  logic             fsm_pulse_s;
  logic             rep_pulse_s;

  assign sync_s = sync_r[1];

  // Synchroniser, FSM state, counter and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_r  <= 2'b00;
      state_r <= IDLE;
      cnt_r   <= '0;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], raw};
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
      pulse_r <= pulse_nxt;
    end
  end

  // Debounce next-state, counter and level/press-pulse decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    level_s     = level_r;
    fsm_pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync_s) begin
          state_s = PRESS_WAIT;
          cnt_s   = '0;
        end else begin
          cnt_s   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_s) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_s     = HELD;
          cnt_s       = '0;
          level_s     = 1'b1;
          fsm_pulse_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      HELD: begin
        if (!sync_s) begin
          state_s = RELEASE_WAIT;
          cnt_s   = '0;
        end else begin
          state_s = HELD;
        end
      end
      RELEASE_WAIT: begin
        // A return to HELD is the same press, so it must not pulse again.
        if (sync_s) begin
          state_s = HELD;
          cnt_s   = '0;
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_s = IDLE;
          cnt_s   = '0;
          level_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        level_s = 1'b0;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  logic [CNT_W-1:0] rcnt_r, rcnt_s;
  logic             rphase_r, rphase_s;

  // Repeat counter and first-delay-done flag registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rcnt_r   <= '0;
      rphase_r <= 1'b0;
    end else begin
      rcnt_r   <= rcnt_s;
      rphase_r <= rphase_s;
    end
  end

  // Repeat timing: runs only while staying in HELD, cleared on any other path
  always_comb begin
    rcnt_s      = rcnt_r;
    rphase_s    = rphase_r;
    rep_pulse_s = 1'b0;
    if (REPEAT_EN && (state_r == HELD) && (state_s == HELD)) begin
      if (!rphase_r && (rcnt_r == CNT_W'(REPEAT_DELAY - 1))) begin
        rep_pulse_s = 1'b1;
        rcnt_s      = '0;
        rphase_s    = 1'b1;
      end else if (rphase_r && (rcnt_r == CNT_W'(REPEAT_PERIOD - 1))) begin
        rep_pulse_s = 1'b1;
        rcnt_s      = '0;
      end else begin
        rcnt_s = rcnt_r + CNT_W'(1'b1);
      end
    end else begin
      rcnt_s   = '0;
      rphase_s = 1'b0;
    end
  end
`else
  assign rep_pulse_s = 1'b0;
`endif

  assign pulse_nxt = fsm_pulse_s | rep_pulse_s;
  assign pulse     = pulse_r;
  assign level     = level_r;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: NUM_BTN independent debounce channels plus a registered
// OR of their strobes. Define BTN_REPEAT_EN to enable auto-repeat.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int               NUM_BTN         = DEF_NUM_BTN,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int               REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK   = DEF_REPEAT_MASK
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               any_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  logic [NUM_BTN-1:0] pulse_nxt_s;
  logic               any_pulse_r;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BTN_REPEAT_EN
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i]),
`endif
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .nrst      (nrst),
      .raw       (btn_raw[i]),
      .pulse     (btn_pulse[i]),
      .pulse_nxt (pulse_nxt_s[i]),
      .level     (btn_level[i])
    );
  end

  // OR of next-cycle strobes so any_pulse lands in the same cycle as btn_pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      any_pulse_r <= 1'b0;
    end else begin
      any_pulse_r <= |pulse_nxt_s;
    end
  end

  assign any_pulse = any_pulse_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: expected strobes are queued per
// clock edge when stimulus is driven and compared by a monitor every cycle.
module tb_button_conditioner;

  localparam int NB   = 5;
  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;

  logic          clk = 1'b0;
  logic          nrst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_level;
  logic          any_pulse;

  typedef struct {
    int            edge_n;
    logic [NB-1:0] pulse;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  button_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER),
    .REPEAT_MASK     (5'b11110)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level),
    .any_pulse (any_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: a strobe is required exactly on queued edges, zero elsewhere
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (sb_q.size() > 0 && sb_q[0].edge_n == cyc) begin
        mon_e = sb_q.pop_front();
        if (btn_pulse !== mon_e.pulse || any_pulse !== 1'b1) begin
          failures++;
          $display("FAIL strobe cyc=%0d btn_pulse=%b any_pulse=%b required %b/1",
                   cyc, btn_pulse, any_pulse, mon_e.pulse);
        end
      end else if (btn_pulse !== 5'b00000 || any_pulse !== 1'b0) begin
        failures++;
        $display("FAIL idle_strobe cyc=%0d btn_pulse=%b any_pulse=%b required 00000/0",
                 cyc, btn_pulse, any_pulse);
      end
    end
  end

  // Edge k after stimulus set at negedge with count base is sampled at cyc base+1+k
  function automatic void push_exp(input int base, input int k, input logic [NB-1:0] p);
    exp_t e;
    e.edge_n = base + 1 + k;
    e.pulse  = p;
    sb_q.push_back(e);
  endfunction

  task automatic test_reset;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if (btn_pulse !== 5'b00000 || btn_level !== 5'b00000 || any_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs pulse=%b level=%b any=%b required 0", btn_pulse, btn_level, any_pulse);
    end
    repeat (2) @(negedge clk);
    nrst   = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (btn_level !== 5'b00000) begin
      failures++;
      $display("FAIL reset_idle_level level=%b required 00000", btn_level);
    end
  endtask

  task automatic test_clean_press;
    int base;
    @(negedge clk);
    base       = cyc;
    btn_raw[0] = 1'b1;
    push_exp(base, DEB + 2, 5'b00001);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (btn_level[0] !== 1'(k >= DEB + 2)) begin
        failures++;
        $display("FAIL press_level edge=%0d level0=%b required %b", k, btn_level[0], 1'(k >= DEB + 2));
      end
    end
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (btn_level[0] !== 1'(k < DEB + 2)) begin
        failures++;
        $display("FAIL release_level k=%0d level0=%b required %b", k, btn_level[0], 1'(k < DEB + 2));
      end
    end
  endtask

  task automatic test_bounce;
    logic [4:0] pat;
    pat = 5'b11011;
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      btn_raw[1] = pat[i];
    end
    @(negedge clk);
    btn_raw[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (btn_level[1] !== 1'b0) begin
        failures++;
        $display("FAIL bounce_level k=%0d level1=%b required 0", k, btn_level[1]);
      end
    end
  endtask

  task automatic test_release_glitch;
    int base;
    @(negedge clk);
    base       = cyc;
    btn_raw[2] = 1'b1;
    push_exp(base, DEB + 2, 5'b00100);
    repeat (12) @(negedge clk);
    checks++;
    if (btn_level[2] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_held_level level2=%b required 1", btn_level[2]);
    end
    btn_raw[2] = 1'b0;
    repeat (2) @(negedge clk);
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (btn_level[2] !== 1'b1) begin
        failures++;
        $display("FAIL glitch_level k=%0d level2=%b required 1", k, btn_level[2]);
      end
    end
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (btn_level[2] !== 1'(k < DEB + 2)) begin
        failures++;
        $display("FAIL glitch_release k=%0d level2=%b required %b", k, btn_level[2], 1'(k < DEB + 2));
      end
    end
  endtask

  task automatic test_simultaneous;
    int base;
    @(negedge clk);
    base    = cyc;
    btn_raw = 5'b00101;
    push_exp(base, DEB + 2, 5'b00101);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== ((k >= DEB + 2) ? 5'b00101 : 5'b00000)) begin
        failures++;
        $display("FAIL simul_level edge=%0d level=%b", k, btn_level);
      end
    end
    btn_raw = 5'b00000;
    repeat (10) @(negedge clk);
    checks++;
    if (btn_level !== 5'b00000) begin
      failures++;
      $display("FAIL simul_release level=%b required 00000", btn_level);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    @(negedge clk);
    base       = cyc;
    btn_raw[0] = 1'b1;
    push_exp(base, DEB + 2, 5'b00001);
    repeat (8) @(negedge clk);
    checks++;
    if (btn_level !== 5'b00001) begin
      failures++;
      $display("FAIL pre_reset_level level=%b required 00001", btn_level);
    end
    btn_raw[4] = 1'b1;
    repeat (4) @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if (btn_level !== 5'b00000 || btn_pulse !== 5'b00000 || any_pulse !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset level=%b pulse=%b any=%b required 0", btn_level, btn_pulse, any_pulse);
    end
    @(negedge clk);
    nrst = 1'b1;
    base = cyc;
    push_exp(base, DEB + 2, 5'b10001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== ((k >= DEB + 2) ? 5'b10001 : 5'b00000)) begin
        failures++;
        $display("FAIL post_reset_level edge=%0d level=%b", k, btn_level);
      end
    end
    btn_raw = 5'b00000;
    repeat (10) @(negedge clk);
    checks++;
    if (btn_level !== 5'b00000) begin
      failures++;
      $display("FAIL post_reset_release level=%b required 00000", btn_level);
    end
  endtask

`ifdef BTN_REPEAT_EN
  task automatic test_repeat;
    int base;
    int first;
    @(negedge clk);
    base    = cyc;
    btn_raw = 5'b01001;
    first   = DEB + 2 + RDLY;
    push_exp(base, DEB + 2, 5'b01001);
    push_exp(base, first, 5'b01000);
    for (int e = first + RPER; e <= first + 4 * RPER; e += RPER) push_exp(base, e, 5'b01000);
    repeat (28) @(negedge clk);
    btn_raw = 5'b00000;
    repeat (12) @(negedge clk);
    checks++;
    if (btn_level !== 5'b00000) begin
      failures++;
      $display("FAIL repeat_release level=%b required 00000", btn_level);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst    = 1'b1;
    btn_raw = 5'b00000;
    test_reset;
    test_clean_press;
    test_bounce;
    test_release_glitch;
    test_simultaneous;
    test_reset_mid;
`ifdef BTN_REPEAT_EN
    test_repeat;
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain outstanding=%0d required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
